// File: rtl/agnus_blitter_pkg.sv
// ---------------------------------------------------------------------------
// agnus_blitter_pkg
// Shared definitions for the blitter channel source stages (A, B, C) and the
// D-channel address stage.
//   MASK_ALL   : all-ones word, used when no edge mask applies
//   WBITS_ECS  : ECS width counter size (BLTSIZH)
//   HBITS_ECS  : ECS height counter size (BLTSIZV)
//   word_pos_t : {first, last} position of a word within its line
// ---------------------------------------------------------------------------
package agnus_blitter_pkg;

    localparam logic [15:0] MASK_ALL  = 16'hFFFF;
    localparam int          WBITS_ECS = 11;
    localparam int          HBITS_ECS = 15;

    typedef struct packed {
        logic first;
        logic last;
    } word_pos_t;

endpackage

// File: rtl/agnus_blitter_sizecnt.sv
// ---------------------------------------------------------------------------
// agnus_blitter_sizecnt
// Width/height down-counters that track where the next word sits in the blit.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   clk7_en        : clock enable, counters only move when high
//   load           : latch width/height and restart at the first word
//   advance        : one word has been taken at the current position
//   width, height  : blit size; 0 encodes 2^WBITS words / 2^HBITS lines
//   pos            : {first, last} flags for the word at the current position
//   final_word     : current position is the last word of the last line
// ---------------------------------------------------------------------------
module agnus_blitter_sizecnt
    import agnus_blitter_pkg::*;
#(
    parameter int WBITS = WBITS_ECS,
    parameter int HBITS = HBITS_ECS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk7_en,
    input  logic             load,
    input  logic             advance,
    input  logic [WBITS-1:0] width,
    input  logic [HBITS-1:0] height,
    output word_pos_t        pos,
    output logic             final_word
);

    logic [WBITS-1:0] width_q, width_d;
    logic [WBITS-1:0] wcnt_q, wcnt_d;
    logic [HBITS-1:0] hcnt_q, hcnt_d;

    // A zero size starts the counter at 0; the first decrement wraps to the
    // top of the range, so the count naturally runs 2^N steps down to 1.
    always_comb begin
        pos.first  = (wcnt_q == width_q);
        pos.last   = (wcnt_q == WBITS'(1));
        final_word = pos.last && (hcnt_q == HBITS'(1));
    end

    always_comb begin
        width_d = width_q;
        wcnt_d  = wcnt_q;
        hcnt_d  = hcnt_q;
        if (clk7_en) begin
            if (load) begin
                width_d = width;
                wcnt_d  = width;
                hcnt_d  = height;
            end else if (advance) begin
                if (pos.last) begin
                    wcnt_d = width_q;
                    hcnt_d = hcnt_q - HBITS'(1);
                end else begin
                    wcnt_d = wcnt_q - WBITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width_q <= '0;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            width_q <= width_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

endmodule

// File: rtl/agnus_blitter_adata.sv
// ---------------------------------------------------------------------------
// agnus_blitter_adata
// Blitter channel A source stage. Masks fetched A words with the first/last
// word masks and hands {new, old} word pairs to the barrel shifter through a
// one-entry valid/consume buffer.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   clk7_en               : clock enable, all state advances only when high
//   start                 : latch blit size and restart the stage
//   bltwidth, bltheight   : words per line / lines per blit (0 = 2^N)
//   fwm, lwm              : first-word and last-word masks
//   data_in, data_valid   : fetched A word and its qualifier
//   data_ready            : stage can take a word this cycle
//   consume               : downstream takes the current pair
//   new_val, old_val      : masked current word and previous masked word
//   out_valid             : an unconsumed pair is held
//   first_word, last_word : line position of new_val
//   busy, done            : blit in progress / completion pulse
// Build option:
//   BLITTER_A_LINECLR_EN  : clear old_val on the first word of every line
//                           instead of carrying it over from the previous line
// ---------------------------------------------------------------------------
module agnus_blitter_adata
    import agnus_blitter_pkg::*;
#(
    parameter int WBITS = WBITS_ECS,
    parameter int HBITS = HBITS_ECS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk7_en,
    input  logic             start,
    input  logic [WBITS-1:0] bltwidth,
    input  logic [HBITS-1:0] bltheight,
    input  logic [15:0]      fwm,
    input  logic [15:0]      lwm,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             consume,
    output logic [15:0]      new_val,
    output logic [15:0]      old_val,
    output logic             out_valid,
    output logic             first_word,
    output logic             last_word,
    output logic             busy,
    output logic             done
);

    logic [15:0] new_val_q, new_val_d;
    logic [15:0] old_val_q, old_val_d;
    logic        out_valid_q, out_valid_d;
    logic        first_word_q, first_word_d;
    logic        last_word_q, last_word_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    // final_held: the buffered pair holds the last word of the blit.
    // final_taken: the last word has been accepted, stop accepting.
    logic        final_held_q, final_held_d;
    logic        final_taken_q, final_taken_d;

    word_pos_t   pos;
    logic        final_word;
    logic        accept;
    logic        take;
    logic [15:0] masked;

    assign data_ready = busy_q && (!out_valid_q || consume) && !final_taken_q;
    assign accept     = clk7_en && data_valid && data_ready && !start;
    assign take       = clk7_en && consume && out_valid_q && !start;
    assign masked     = data_in & (pos.first ? fwm : MASK_ALL)
                                & (pos.last  ? lwm : MASK_ALL);

    agnus_blitter_sizecnt #(
        .WBITS (WBITS),
        .HBITS (HBITS)
    ) u_sizecnt (
        .clk        (clk),
        .reset      (reset),
        .clk7_en    (clk7_en),
        .load       (start),
        .advance    (accept),
        .width      (bltwidth),
        .height     (bltheight),
        .pos        (pos),
        .final_word (final_word)
    );

    // Start wins over everything. Otherwise a take empties the buffer and an
    // accept in the same cycle refills it, giving one pair per enabled cycle.
    always_comb begin
        new_val_d     = new_val_q;
        old_val_d     = old_val_q;
        out_valid_d   = out_valid_q;
        first_word_d  = first_word_q;
        last_word_d   = last_word_q;
        busy_d        = busy_q;
        done_d        = done_q;
        final_held_d  = final_held_q;
        final_taken_d = final_taken_q;
        if (clk7_en) begin
            done_d = 1'b0;
            if (start) begin
                busy_d        = 1'b1;
                out_valid_d   = 1'b0;
                new_val_d     = '0;
                old_val_d     = '0;
                first_word_d  = 1'b0;
                last_word_d   = 1'b0;
                final_held_d  = 1'b0;
                final_taken_d = 1'b0;
            end else begin
                if (take) begin
                    out_valid_d = 1'b0;
                    if (final_held_q) begin
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        final_held_d = 1'b0;
                    end
                end
                if (accept) begin
`ifdef BLITTER_A_LINECLR_EN
                    old_val_d = pos.first ? 16'h0000 : new_val_q;
`else
                    old_val_d = new_val_q;
`endif
                    new_val_d    = masked;
                    first_word_d = pos.first;
                    last_word_d  = pos.last;
                    out_valid_d  = 1'b1;
                    final_held_d = final_word;
                    if (final_word) begin
                        final_taken_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_val_q     <= '0;
            old_val_q     <= '0;
            out_valid_q   <= 1'b0;
            first_word_q  <= 1'b0;
            last_word_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            final_held_q  <= 1'b0;
            final_taken_q <= 1'b0;
        end else begin
            new_val_q     <= new_val_d;
            old_val_q     <= old_val_d;
            out_valid_q   <= out_valid_d;
            first_word_q  <= first_word_d;
            last_word_q   <= last_word_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            final_held_q  <= final_held_d;
            final_taken_q <= final_taken_d;
        end
    end

    assign new_val    = new_val_q;
    assign old_val    = old_val_q;
    assign out_valid  = out_valid_q;
    assign first_word = first_word_q;
    assign last_word  = last_word_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_agnus_blitter_adata.sv
// ---------------------------------------------------------------------------
// tb_agnus_blitter_adata
// Self-checking bench for the blitter channel A source stage. Word-level
// expectations come from a constant table; expected pairs are queued when a
// word is driven and compared when the pair is consumed.
// ---------------------------------------------------------------------------
module tb_agnus_blitter_adata;

    typedef struct {
        logic        newBlit;
        logic [10:0] width;
        logic [14:0] height;
        logic [15:0] fwm;
        logic [15:0] lwm;
        logic [15:0] data;
        logic [15:0] expNew;
        logic [15:0] expOld;
        logic        expFirst;
        logic        expLast;
    } vec_t;

    typedef struct {
        logic [15:0] newVal;
        logic [15:0] oldVal;
        logic        first;
        logic        last;
    } exp_t;

`ifdef BLITTER_A_LINECLR_EN
    localparam logic [15:0] CARRY_1W = 16'h0000;
    localparam logic [15:0] CARRY_2W = 16'h0000;
`else
    localparam logic [15:0] CARRY_1W = 16'h0F00;
    localparam logic [15:0] CARRY_2W = 16'h0505;
`endif

    logic        clk;
    logic        reset;
    logic        clk7_en;
    logic        start;
    logic [10:0] bltwidth;
    logic [14:0] bltheight;
    logic [15:0] fwm;
    logic [15:0] lwm;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        consume;
    logic [15:0] new_val;
    logic [15:0] old_val;
    logic        out_valid;
    logic        first_word;
    logic        last_word;
    logic        busy;
    logic        done;

    int   assertCount = 0;
    int   failCount   = 0;
    int   doneCount   = 0;
    int   duty        = 1;
    int   cyc         = 0;
    logic sbOn        = 1'b0;
    logic donePrev    = 1'b0;
    exp_t sbQ[$];
    vec_t vecs[9];

    agnus_blitter_adata dut (
        .clk        (clk),
        .reset      (reset),
        .clk7_en    (clk7_en),
        .start      (start),
        .bltwidth   (bltwidth),
        .bltheight  (bltheight),
        .fwm        (fwm),
        .lwm        (lwm),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .consume    (consume),
        .new_val    (new_val),
        .old_val    (old_val),
        .out_valid  (out_valid),
        .first_word (first_word),
        .last_word  (last_word),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: a pair shown with consume high on an enabled cycle is
    // taken at the next edge, so it is compared against the oldest entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (sbOn && clk7_en && out_valid && consume) begin
                if (sbQ.size() == 0) begin
                    checkOutput("sbUnderflow", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("newVal", 64'(new_val), 64'(e.newVal));
                    checkOutput("oldVal", 64'(old_val), 64'(e.oldVal));
                    checkOutput("firstWord", 64'(first_word), 64'(e.first));
                    checkOutput("lastWord", 64'(last_word), 64'(e.last));
                end
            end
            if (done && !donePrev) doneCount++;
            donePrev = done;
        end
    end

    // One clock; registers must hold across disabled edges and done must not
    // survive an enabled edge.
    task automatic tick(output logic wasEn);
        logic [36:0] snap;
        logic        doneBefore;
        wasEn      = clk7_en;
        doneBefore = done;
        snap       = {new_val, old_val, out_valid, first_word, last_word, busy, done};
        @(posedge clk);
        #1;
        if (!wasEn)
            checkOutput("holdRegs",
                        64'({new_val, old_val, out_valid, first_word, last_word, busy, done}),
                        64'(snap));
        else if (doneBefore)
            checkOutput("donePulse", 64'(done), 64'(0));
        cyc++;
        clk7_en = ((cyc % duty) == 0);
    endtask

    task automatic enabledTick();
        logic en;
        en = 1'b0;
        for (int k = 0; k < 16 && !en; k++) tick(en);
        if (!en) checkOutput("enableTimeout", 64'(0), 64'(1));
    endtask

    task automatic startBlit(input logic [10:0] w, input logic [14:0] h,
                             input logic [15:0] f, input logic [15:0] l);
        bltwidth  = w;
        bltheight = h;
        fwm       = f;
        lwm       = l;
        start     = 1'b1;
        enabledTick();
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] word, input exp_t e);
        logic acc;
        logic en;
        acc = 1'b0;
        sbQ.push_back(e);
        data_in    = word;
        data_valid = 1'b1;
        for (int k = 0; k < 64 && !acc; k++) begin
            #1;
            acc = clk7_en && data_ready;
            tick(en);
        end
        if (!acc) checkOutput("acceptTimeout", 64'(0), 64'(1));
        data_valid = 1'b0;
    endtask

    task automatic waitIdle(input int expDone);
        logic en;
        for (int k = 0; k < 400 && busy; k++) tick(en);
        checkOutput("busyClear", 64'(busy), 64'(0));
        tick(en);
        checkOutput("doneCount", 64'(doneCount), 64'(expDone));
        checkOutput("sbEmpty", 64'(sbQ.size()), 64'(0));
    endtask

    initial begin
        logic en;
        int   blits;
        exp_t e;

        vecs[0] = '{1'b1, 11'd3, 15'd1, 16'h0FFF, 16'hFFF0, 16'hFFFF, 16'h0FFF, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 11'd3, 15'd1, 16'h0FFF, 16'hFFF0, 16'hFFFF, 16'hFFFF, 16'h0FFF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 11'd3, 15'd1, 16'h0FFF, 16'hFFF0, 16'hFFFF, 16'hFFF0, 16'hFFFF, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 11'd1, 15'd2, 16'hFF00, 16'h0FF0, 16'hFFFF, 16'h0F00, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 11'd1, 15'd2, 16'hFF00, 16'h0FF0, 16'hFFFF, 16'h0F00, CARRY_1W, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 11'd2, 15'd2, 16'hF0F0, 16'h0F0F, 16'hAAAA, 16'hA0A0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 11'd2, 15'd2, 16'hF0F0, 16'h0F0F, 16'h5555, 16'h0505, 16'hA0A0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 11'd2, 15'd2, 16'hF0F0, 16'h0F0F, 16'h1234, 16'h1030, CARRY_2W, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 11'd2, 15'd2, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0F0F, 16'h1030, 1'b0, 1'b1};

        reset      = 1'b1;
        clk7_en    = 1'b1;
        start      = 1'b0;
        bltwidth   = '0;
        bltheight  = '0;
        fwm        = '0;
        lwm        = '0;
        data_in    = '0;
        data_valid = 1'b0;
        consume    = 1'b0;

        #2;
        checkOutput("resetOutputs",
                    64'({new_val, old_val, out_valid, first_word, last_word, busy, done, data_ready}),
                    64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table run at full rate, then with clk7_en at 1/4 duty.
        blits = 0;
        sbOn  = 1'b1;
        consume = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            duty    = (pass == 0) ? 1 : 4;
            clk7_en = ((cyc % duty) == 0);
            for (int i = 0; i < 9; i++) begin
                if (vecs[i].newBlit) begin
                    if (i > 0) begin
                        blits++;
                        waitIdle(blits);
                    end
                    startBlit(vecs[i].width, vecs[i].height, vecs[i].fwm, vecs[i].lwm);
                end
                e.newVal = vecs[i].expNew;
                e.oldVal = vecs[i].expOld;
                e.first  = vecs[i].expFirst;
                e.last   = vecs[i].expLast;
                applyStimulus(vecs[i].data, e);
            end
            blits++;
            waitIdle(blits);
        end
        sbOn    = 1'b0;
        duty    = 1;
        clk7_en = 1'b1;

        // Backpressure: held pair blocks new words until consume returns.
        consume = 1'b0;
        startBlit(11'd3, 15'd1, 16'hFFFF, 16'hFFFF);
        data_in    = 16'h1111;
        data_valid = 1'b1;
        #1;
        tick(en);
        checkOutput("bpOutValid", 64'(out_valid), 64'(1));
        checkOutput("bpFirstNew", 64'(new_val), 64'(16'h1111));
        data_in = 16'h2222;
        #1;
        checkOutput("bpReadyLow", 64'(data_ready), 64'(0));
        tick(en);
        tick(en);
        checkOutput("bpHoldNew", 64'(new_val), 64'(16'h1111));
        checkOutput("bpHoldOld", 64'(old_val), 64'(16'h0000));
        consume = 1'b1;
        #1;
        checkOutput("bpReadyComb", 64'(data_ready), 64'(1));
        tick(en);
        checkOutput("bpPairNew", 64'(new_val), 64'(16'h2222));
        checkOutput("bpPairOld", 64'(old_val), 64'(16'h1111));
        checkOutput("bpStillValid", 64'(out_valid), 64'(1));
        data_in = 16'h3333;
        tick(en);
        checkOutput("bpLastWord", 64'({new_val, last_word}), 64'({16'h3333, 1'b1}));
        data_valid = 1'b0;
        tick(en);
        checkOutput("bpDone", 64'({done, busy, out_valid}), 64'({1'b1, 1'b0, 1'b0}));
        consume = 1'b0;
        tick(en);

        // Abort mid-blit and restart from the first word.
        consume = 1'b1;
        startBlit(11'd4, 15'd1, 16'h00FF, 16'hFF00);
        data_in    = 16'hFFFF;
        data_valid = 1'b1;
        tick(en);
        tick(en);
        checkOutput("abMidNew", 64'({new_val, old_val, first_word}),
                    64'({16'hFFFF, 16'h00FF, 1'b0}));
        start = 1'b1;
        tick(en);
        start = 1'b0;
        checkOutput("abCleared", 64'({out_valid, old_val, new_val, busy}),
                    64'({1'b0, 16'h0000, 16'h0000, 1'b1}));
        tick(en);
        checkOutput("abFirstMask", 64'({new_val, old_val, first_word}),
                    64'({16'h00FF, 16'h0000, 1'b1}));
        tick(en);
        checkOutput("abReloaded", 64'({new_val, old_val, first_word, last_word}),
                    64'({16'hFFFF, 16'h00FF, 1'b0, 1'b0}));

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncReset", 64'({busy, out_valid, done, data_ready, new_val}),
                    64'(0));
        @(negedge clk);
        reset      = 1'b0;
        data_valid = 1'b0;
        consume    = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
